// File: rtl/serial_subtractor8_pkg.sv
// sub_pkg: shared FSM state encodings and default operand width for serial_subtractor8.
package sub_pkg;
    localparam int WIDTH_DEF = 8;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;
endpackage

// File: rtl/serial_subtractor8_fullsubtractor.sv
// fullsubtractor: one-bit difference and borrow-out cell.
module fullsubtractor (
    input  logic a,
    input  logic b,
    input  logic bi,
    output logic d,
    output logic bo
);
    assign d  = a ^ b ^ bi;
    assign bo = (~a & b) | (~(a ^ b) & bi);
endmodule

// File: rtl/serial_subtractor8.sv
// serial_subtractor8: bit-serial d = a - b - bin, LSB first, valid/ready on both sides.
// Defining SUB_OVF_FLAG_EN adds the signed-overflow output ovf.
module serial_subtractor8
    import sub_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout
`ifdef SUB_OVF_FLAG_EN
    ,
    output logic             ovf
`endif
);
    localparam int CW = $clog2(WIDTH);
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] sa, sb;
    logic [WIDTH-2:0] res;
    logic br, diff, br_n, last;
    assign last      = cnt == CW'(WIDTH - 1);
    assign in_ready  = state == ST_IDLE;
    assign out_valid = state == ST_DONE;
    fullsubtractor u_fs (
        .a (sa[0]),
        .b (sb[0]),
        .bi(br),
        .d (diff),
        .bo(br_n)
    );
    always_comb begin
        state_n = state;
        state_n = (state == ST_IDLE && in_valid)  ? ST_BUSY :
                  (state == ST_BUSY && last)      ? ST_DONE :
                  (state == ST_DONE && out_ready) ? ST_IDLE : state;
    end
    always_ff @(posedge clk) begin
        state <= rst ? ST_IDLE : state_n;
    end
    // Operand and result shifters; the last BUSY edge folds the final bit straight into d.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            sa   <= '0;
            sb   <= '0;
            res  <= '0;
            br   <= 1'b0;
            d    <= '0;
            bout <= 1'b0;
`ifdef SUB_OVF_FLAG_EN
            ovf  <= 1'b0;
`endif
        end else if (state == ST_IDLE && in_valid) begin
            sa  <= a;
            sb  <= b;
            br  <= bin;
            cnt <= '0;
        end else if (state == ST_BUSY) begin
            sa  <= sa >> 1;
            sb  <= sb >> 1;
            res <= (WIDTH-1)'({diff, res} >> 1);
            br  <= br_n;
            cnt <= cnt + CW'(1);
            if (last) begin
                d    <= {diff, res};
                bout <= br_n;
`ifdef SUB_OVF_FLAG_EN
                ovf  <= br ^ br_n;
`endif
            end
        end
    end
endmodule
